// File: rtl/lab2_seq_detector_if.sv
// Sample/result bundle between the lab 2 function stage and the 1011 detector.
interface lab2_seq_detector_if #(
    parameter int unsigned CW = 8
);
    logic          en;
    logic          z_in;
    logic          detect;
    logic [CW-1:0] match_count;
    logic [3:0]    history;
    logic [2:0]    state;

    modport master (
        output en, z_in,
        input  detect, match_count, history, state
    );

    modport slave (
        input  en, z_in,
        output detect, match_count, history, state
    );
endinterface

// File: rtl/lab2_seq_detector.sv
// Moore detector for serial pattern 1011 on the function-stage output z, with
// saturating match counter and 4-bit sample history.
module lab2_seq_detector #(
    parameter bit          OVERLAP = 1'b1,
    parameter int unsigned CW      = 8
) (
    input  logic                clock,
    input  logic                reset,
    lab2_seq_detector_if.slave  bus
);
    localparam int unsigned HW = 4;
    localparam logic [CW-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        S0    = 3'd0,
        S1    = 3'd1,
        S10   = 3'd2,
        S101  = 3'd3,
        S1011 = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [HW-1:0] hist_q, hist_d;
    logic          detect_q, detect_d;

    // Next-state, counter and history; everything holds while en is low.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        hist_d   = hist_q;
        if (bus.en) begin
            hist_d = {hist_q[HW-2:0], bus.z_in};
            case (state_q)
                S0:      state_d = bus.z_in ? S1    : S0;
                S1:      state_d = bus.z_in ? S1    : S10;
                S10:     state_d = bus.z_in ? S101  : S0;
                S101:    state_d = bus.z_in ? S1011 : S10;
                S1011:   state_d = bus.z_in ? S1    : (OVERLAP ? S10 : S0);
                default: state_d = S0;
            endcase
            // Count only on the entering edge so a parked S1011 never recounts.
            if ((state_q == S101) && bus.z_in && (count_q != CNT_MAX)) begin
                count_d = count_q + CW'(1);
            end
        end
        detect_d = (state_d == S1011);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S0;
            count_q  <= '0;
            hist_q   <= '0;
            detect_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            hist_q   <= hist_d;
            detect_q <= detect_d;
        end
    end

    assign bus.state       = state_q;
    assign bus.detect      = detect_q;
    assign bus.match_count = count_q;
    assign bus.history     = hist_q;
endmodule

// File: tb/tb_lab2_seq_detector.sv
// Scoreboard bench for lab2_seq_detector: three configurations driven with
// directed vectors, expectations queued at issue and checked by a monitor.
module tb_lab2_seq_detector;
    logic clock;
    logic [2:0] rst_v;
    logic [2:0] en_v;
    logic [2:0] z_v;

    typedef struct {
        int         vec;
        int         dut;
        logic [2:0] st;
        logic [7:0] cnt;
        logic [3:0] hist;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   n_issued = 0;

    // dut0: overlap, CW=8; dut1: non-overlap, CW=8; dut2: overlap, CW=2
    lab2_seq_detector_if #(.CW(8)) if0 ();
    lab2_seq_detector_if #(.CW(8)) if1 ();
    lab2_seq_detector_if #(.CW(2)) if2 ();

    assign if0.en = en_v[0];  assign if0.z_in = z_v[0];
    assign if1.en = en_v[1];  assign if1.z_in = z_v[1];
    assign if2.en = en_v[2];  assign if2.z_in = z_v[2];

    lab2_seq_detector #(.OVERLAP(1'b1), .CW(8)) u_dut0 (.clock(clock), .reset(rst_v[0]), .bus(if0));
    lab2_seq_detector #(.OVERLAP(1'b0), .CW(8)) u_dut1 (.clock(clock), .reset(rst_v[1]), .bus(if1));
    lab2_seq_detector #(.OVERLAP(1'b1), .CW(2)) u_dut2 (.clock(clock), .reset(rst_v[2]), .bus(if2));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step(input int d, input logic r, input logic e, input logic z,
                        input logic [2:0] st, input logic [7:0] cnt, input logic [3:0] h);
        exp_t x;
        rst_v = '0;
        en_v  = '0;
        z_v   = '0;
        rst_v[d] = r;
        en_v[d]  = e;
        z_v[d]   = z;
        @(posedge clock);
        x.vec  = n_issued;
        x.dut  = d;
        x.st   = st;
        x.cnt  = cnt;
        x.hist = h;
        exp_q.push_back(x);
        n_issued++;
        #1;
    endtask

    // Monitor: results settle after the edge, checked on the falling edge.
    always @(negedge clock) begin
        while (exp_q.size() > 0) begin
            exp_t       e;
            logic [2:0] a_st;
            logic       a_det;
            logic [7:0] a_cnt;
            logic [3:0] a_h;
            e = exp_q.pop_front();
            case (e.dut)
                0:       begin a_st = if0.state; a_det = if0.detect; a_cnt = if0.match_count;      a_h = if0.history; end
                1:       begin a_st = if1.state; a_det = if1.detect; a_cnt = if1.match_count;      a_h = if1.history; end
                default: begin a_st = if2.state; a_det = if2.detect; a_cnt = 8'(if2.match_count); a_h = if2.history; end
            endcase
            n_vec++;
            if (a_st !== e.st || a_det !== (e.st == 3'd4) || a_cnt !== e.cnt || a_h !== e.hist) begin
                n_bad++;
                $display("FAIL vec%0d dut%0d: state=%0d exp %0d, detect=%b exp %b, count=%0d exp %0d, history=%b exp %b",
                         e.vec, e.dut, a_st, e.st, a_det, (e.st == 3'd4), a_cnt, e.cnt, a_h, e.hist);
            end
        end
    end

    initial begin
        rst_v = '0;
        en_v  = '0;
        z_v   = '0;

        // dut0: reset with en=1,z=1, then one idle cycle after release
        step(0, 1, 1, 1, 3'd0, 8'd0, 4'b0000);
        step(0, 1, 1, 1, 3'd0, 8'd0, 4'b0000);
        step(0, 0, 0, 1, 3'd0, 8'd0, 4'b0000);
        // overlapping stream 1011011
        step(0, 0, 1, 1, 3'd1, 8'd0, 4'b0001);
        step(0, 0, 1, 0, 3'd2, 8'd0, 4'b0010);
        step(0, 0, 1, 1, 3'd3, 8'd0, 4'b0101);
        step(0, 0, 1, 1, 3'd4, 8'd1, 4'b1011);
        step(0, 0, 1, 0, 3'd2, 8'd1, 4'b0110);
        step(0, 0, 1, 1, 3'd3, 8'd1, 4'b1101);
        step(0, 0, 1, 1, 3'd4, 8'd2, 4'b1011);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1'(i), 3'd4, 8'd2, 4'b1011);
        // enable gating then parked match
        step(0, 1, 1, 1, 3'd0, 8'd0, 4'b0000);
        step(0, 0, 1, 1, 3'd1, 8'd0, 4'b0001);
        step(0, 0, 1, 0, 3'd2, 8'd0, 4'b0010);
        step(0, 0, 1, 1, 3'd3, 8'd0, 4'b0101);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1'(i), 3'd3, 8'd0, 4'b0101);
        step(0, 0, 1, 1, 3'd4, 8'd1, 4'b1011);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1'(i + 1), 3'd4, 8'd1, 4'b1011);
        step(0, 0, 1, 1, 3'd1, 8'd1, 4'b0111);

        // dut1: non-overlapping, stream 1011011
        step(1, 1, 1, 1, 3'd0, 8'd0, 4'b0000);
        step(1, 1, 1, 1, 3'd0, 8'd0, 4'b0000);
        step(1, 0, 1, 1, 3'd1, 8'd0, 4'b0001);
        step(1, 0, 1, 0, 3'd2, 8'd0, 4'b0010);
        step(1, 0, 1, 1, 3'd3, 8'd0, 4'b0101);
        step(1, 0, 1, 1, 3'd4, 8'd1, 4'b1011);
        step(1, 0, 1, 0, 3'd0, 8'd1, 4'b0110);
        step(1, 0, 1, 1, 3'd1, 8'd1, 4'b1101);
        step(1, 0, 1, 1, 3'd1, 8'd1, 4'b1011);

        // dut2: CW=2 saturation over five back-to-back 1011 groups
        step(2, 1, 0, 0, 3'd0, 8'd0, 4'b0000);
        for (int g = 0; g < 5; g++) begin
            logic [7:0] c_pre, c_post;
            c_pre  = (g > 3) ? 8'd3 : 8'(g);
            c_post = (g + 1 > 3) ? 8'd3 : 8'(g + 1);
            step(2, 0, 1, 1, 3'd1, c_pre,  (g == 0) ? 4'b0001 : 4'b0111);
            step(2, 0, 1, 0, 3'd2, c_pre,  (g == 0) ? 4'b0010 : 4'b1110);
            step(2, 0, 1, 1, 3'd3, c_pre,  (g == 0) ? 4'b0101 : 4'b1101);
            step(2, 0, 1, 1, 3'd4, c_post, 4'b1011);
        end
        // partial match discarded by reset mid-sequence
        step(2, 0, 1, 1, 3'd1, 8'd3, 4'b0111);
        step(2, 0, 1, 0, 3'd2, 8'd3, 4'b1110);
        step(2, 0, 1, 1, 3'd3, 8'd3, 4'b1101);
        step(2, 1, 1, 1, 3'd0, 8'd0, 4'b0000);
        step(2, 0, 1, 1, 3'd1, 8'd0, 4'b0001);

        en_v = '0;
        repeat (2) @(posedge clock);
        if (exp_q.size() != 0 || n_vec != n_issued) begin
            n_bad++;
            $display("FAIL drain: checked=%0d exp %0d", n_vec, n_issued);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
